// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker
//   Turns the 3-byte PS/2 mouse packet stream into an absolute cursor
//   position and button states. The cursor moves by the signed deltas in
//   each packet and is clamped to the screen. A packet is thrown away if it
//   is broken by a receiver error or by an overlong idle gap.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   rx_data, rx_valid      one byte from the PS/2 receiver (1-cycle strobe)
//   rx_error               receiver framing/parity error (1-cycle strobe)
//   mouse_xpos/ypos        cursor position, 0..X_MAX / 0..Y_MAX (0 = top)
//   left/right_mouse       button states from the last complete packet
//   pkt_valid              1-cycle pulse: outputs just updated
//   sync_error             1-cycle pulse: a byte or partial packet was dropped
module mouse_position_tracker #(
    parameter int X_MAX          = 1023,
    parameter int Y_MAX          = 767,
    parameter int X_INIT         = 512,
    parameter int Y_INIT         = 384,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [11:0] mouse_xpos,
    output logic [11:0] mouse_ypos,
    output logic        left_mouse,
    output logic        right_mouse,
    output logic        pkt_valid,
    output logic        sync_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    // Byte 0 fields kept: {y_ovf, x_ovf, y_sign, x_sign, right, left}
    logic [5:0]      hdr_q;
    logic [7:0]      dx_q;
    logic            lat_hdr, lat_dx, pkt_nx, sync_nx, tmo_hit;

    logic [8:0]         dx9, dy9;
    logic signed [12:0] x_sum, y_sum;
    logic [11:0]        x_clamp, y_clamp;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Next state. rx_error takes priority over everything, including a
    // byte arriving in the same cycle.
    always_comb begin
        state_nx = state;
        tmo_nx   = tmo_cnt;
        lat_hdr  = 1'b0;
        lat_dx   = 1'b0;
        pkt_nx   = 1'b0;
        sync_nx  = 1'b0;
        if (rx_error) begin
            state_nx = WAIT_B0;
            tmo_nx   = '0;
            sync_nx  = 1'b1;
        end else begin
            case (state)
                WAIT_B0: begin
                    tmo_nx = '0;
                    if (rx_valid) begin
                        if (rx_data[3]) begin
                            lat_hdr  = 1'b1;
                            state_nx = WAIT_B1;
                        end else begin
                            sync_nx = 1'b1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (rx_valid) begin
                        tmo_nx = '0;
                        if (state == WAIT_B1) begin
                            lat_dx   = 1'b1;
                            state_nx = WAIT_B2;
                        end else begin
                            pkt_nx   = 1'b1;
                            state_nx = WAIT_B0;
                        end
                    end else if (tmo_hit) begin
                        tmo_nx   = '0;
                        sync_nx  = 1'b1;
                        state_nx = WAIT_B0;
                    end else begin
                        tmo_nx = tmo_cnt + 1'b1;
                    end
                end
                default: state_nx = WAIT_B0;
            endcase
        end
    end

    // Deltas are 9-bit two's complement; an overflow flag pins the delta to
    // the extreme of its sign. The Y byte is used straight off rx_data since
    // the update happens in the cycle it arrives.
    always_comb begin
        dx9 = hdr_q[4] ? (hdr_q[2] ? 9'h100 : 9'h0FF) : {hdr_q[2], dx_q};
        dy9 = hdr_q[5] ? (hdr_q[3] ? 9'h100 : 9'h0FF) : {hdr_q[3], rx_data};
        // PS/2 +Y is up, screen +Y is down, hence the subtraction.
        x_sum = $signed({1'b0, mouse_xpos}) + $signed({{4{dx9[8]}}, dx9});
        y_sum = $signed({1'b0, mouse_ypos}) - $signed({{4{dy9[8]}}, dy9});

        if (x_sum[12])                       x_clamp = '0;
        else if (x_sum[11:0] > 12'(X_MAX))   x_clamp = 12'(X_MAX);
        else                                 x_clamp = x_sum[11:0];

        if (y_sum[12])                       y_clamp = '0;
        else if (y_sum[11:0] > 12'(Y_MAX))   y_clamp = 12'(Y_MAX);
        else                                 y_clamp = y_sum[11:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_B0;
            tmo_cnt     <= '0;
            hdr_q       <= '0;
            dx_q        <= '0;
            mouse_xpos  <= 12'(X_INIT);
            mouse_ypos  <= 12'(Y_INIT);
            left_mouse  <= 1'b0;
            right_mouse <= 1'b0;
            pkt_valid   <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            state      <= state_nx;
            tmo_cnt    <= tmo_nx;
            pkt_valid  <= pkt_nx;
            sync_error <= sync_nx;
            if (lat_hdr) hdr_q <= {rx_data[7:4], rx_data[1:0]};
            if (lat_dx)  dx_q  <= rx_data;
            if (pkt_nx) begin
                mouse_xpos  <= x_clamp;
                mouse_ypos  <= y_clamp;
                left_mouse  <= hdr_q[0];
                right_mouse <= hdr_q[1];
            end
        end
    end

endmodule

// File: tb/tb_mouse_position_tracker.sv
module tb_mouse_position_tracker;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        left_mouse, right_mouse, pkt_valid, sync_error;

    mouse_position_tracker #(
        .X_MAX(1023), .Y_MAX(767), .X_INIT(512), .Y_INIT(384), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .left_mouse(left_mouse), .right_mouse(right_mouse),
        .pkt_valid(pkt_valid), .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        l;
        logic        r;
    } exp_t;

    localparam exp_t INIT = '{x: 12'd512, y: 12'd384, l: 1'b0, r: 1'b0};

    exp_t exp_q[$];
    exp_t cur = INIT;
    int   n_chk = 0;
    int   n_fail = 0;
    int   sync_cnt = 0;
    int   exp_sync = 0;

    task automatic check_out(input string name);
        n_chk++;
        if (mouse_xpos !== cur.x || mouse_ypos !== cur.y ||
            left_mouse !== cur.l || right_mouse !== cur.r) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d y=%0d l=%0b r=%0b, expected x=%0d y=%0d l=%0b r=%0b",
                     name, $time, mouse_xpos, mouse_ypos, left_mouse, right_mouse,
                     cur.x, cur.y, cur.l, cur.r);
        end
    endtask

    // Monitor: pops an expected packet result on every pkt_valid and checks
    // the held outputs every cycle, so partial packets must not move them.
    always @(negedge clk) begin
        if (rst) begin
            cur = INIT;
            check_out("reset_state");
            n_chk++;
            if (pkt_valid !== 1'b0 || sync_error !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pulses: got pkt_valid=%0b sync_error=%0b, expected 0 0",
                         pkt_valid, sync_error);
            end
        end else begin
            n_chk++;
            if (pkt_valid === 1'b1 && sync_error === 1'b1) begin
                n_fail++;
                $display("FAIL pulse_overlap @%0t: pkt_valid and sync_error both 1, expected exclusive", $time);
            end
            if (sync_error === 1'b1) sync_cnt++;
            if (pkt_valid === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pkt @%0t: got pkt_valid=1, expected no packet", $time);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            check_out("outputs");
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2,
                            input int ex, ey, input logic el, er);
        exp_t e;
        e.x = 12'(ex);
        e.y = 12'(ey);
        e.l = el;
        e.r = er;
        exp_q.push_back(e);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        // Byte 2 was captured on the previous edge; pkt_valid must already be up.
        @(negedge clk); #1;
        n_chk++;
        if (pkt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pkt_latency @%0t: got pkt_valid=%0b, expected 1", $time, pkt_valid);
        end
    endtask

    task automatic err_pulse(input logic with_byte, input logic [7:0] b);
        @(posedge clk); #1;
        rx_error = 1'b1;
        rx_valid = with_byte;
        rx_data  = b;
        @(posedge clk); #1;
        rx_error = 1'b0;
        rx_valid = 1'b0;
        exp_sync++;
    endtask

    task automatic check_sync(input string name);
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (sync_cnt != exp_sync) begin
            n_fail++;
            $display("FAIL %s: got sync_error count=%0d, expected %0d", name, sync_cnt, exp_sync);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);

        // Basic decode
        send_pkt(8'h09, 8'h10, 8'h05, 528, 379, 1'b1, 1'b0);

        // Y clamp at top, then X clamp at right edge
        do_reset();
        send_pkt(8'h08, 8'h00, 8'h7F, 512, 257, 1'b0, 1'b0);
        send_pkt(8'h08, 8'h00, 8'h7F, 512, 130, 1'b0, 1'b0);
        send_pkt(8'h08, 8'h00, 8'h7F, 512, 3,   1'b0, 1'b0);
        send_pkt(8'h08, 8'h00, 8'h7F, 512, 0,   1'b0, 1'b0);
        send_pkt(8'h08, 8'h7F, 8'h00, 639, 0,   1'b0, 1'b0);
        send_pkt(8'h08, 8'h7F, 8'h00, 766, 0,   1'b0, 1'b0);
        send_pkt(8'h08, 8'h7F, 8'h00, 893, 0,   1'b0, 1'b0);
        send_pkt(8'h08, 8'h6B, 8'h00, 1000, 0,  1'b0, 1'b0);
        send_pkt(8'h08, 8'h7F, 8'h00, 1023, 0,  1'b0, 1'b0);
        send_pkt(8'h08, 8'h7F, 8'h00, 1023, 0,  1'b0, 1'b0);

        // Missing sync bit
        send_byte(8'h00);
        exp_sync++;
        check_sync("sync_bit");
        send_pkt(8'h0A, 8'h00, 8'h00, 1023, 0, 1'b0, 1'b1);

        // Idle timeout mid-packet
        send_byte(8'h08);
        send_byte(8'h10);
        repeat (TMO + 4) @(posedge clk);
        exp_sync++;
        check_sync("timeout");
        send_pkt(8'h09, 8'h00, 8'h00, 1023, 0, 1'b1, 1'b0);

        // Receiver error mid-packet
        send_byte(8'h08);
        send_byte(8'h10);
        err_pulse(1'b0, 8'h00);
        check_sync("rx_error");
        send_pkt(8'h0A, 8'h00, 8'h00, 1023, 0, 1'b0, 1'b1);

        // Error with a byte in the same cycle: the byte is ignored
        err_pulse(1'b1, 8'h08);
        check_sync("err_wins");
        send_pkt(8'h19, 8'hF0, 8'h00, 1007, 0, 1'b1, 1'b0);

        // Overflow saturation in all four directions
        do_reset();
        send_pkt(8'h58, 8'h00, 8'h00, 256, 384, 1'b0, 1'b0);
        send_pkt(8'hA8, 8'h00, 8'h00, 256, 640, 1'b0, 1'b0);
        send_pkt(8'h88, 8'h00, 8'h00, 256, 385, 1'b0, 1'b0);
        send_pkt(8'h48, 8'h00, 8'h00, 511, 385, 1'b0, 1'b0);

        // Reset mid-packet, then a fresh packet from byte 0
        send_byte(8'h08);
        send_byte(8'h10);
        do_reset();
        send_pkt(8'h09, 8'h01, 8'h01, 513, 383, 1'b1, 1'b0);

        // Left edge and bottom edge clamps
        send_pkt(8'h58, 8'h00, 8'h00, 257, 383, 1'b0, 1'b0);
        send_pkt(8'h58, 8'h00, 8'h00, 1,   383, 1'b0, 1'b0);
        send_pkt(8'h18, 8'hFE, 8'h00, 0,   383, 1'b0, 1'b0);
        send_pkt(8'h28, 8'h00, 8'h00, 0,   639, 1'b0, 1'b0);
        send_pkt(8'h28, 8'h00, 8'h00, 0,   767, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        check_sync("final_sync_count");
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_pkts: got %0d undelivered, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
